// File: rtl/ones_rr_arbiter.sv
// Round-robin arbiter for 15 requesters with a bounded grant length, plus a
// registered popcount of the request vector for occupancy monitoring.
module ones_rr_arbiter #(
  parameter int N_REQ    = 15,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       gnt_id,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             timeout
);

  localparam int             ID_W    = 4;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              timeout_q, timeout_d;
  logic [ID_W-1:0]   sel;
  logic              hold_expired;

  // First set bit scanning ptr, ptr+1, ..., wrapping past the last requester.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] pick;
    logic            found;
    logic [ID_W:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, p} + (ID_W + 1)'(i);
      if (idx >= N_REQ_W) idx = idx - N_REQ_W;
      if (!found && r[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] r);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) cnt = cnt + {{(CNT_W-1){1'b0}}, r[i]};
    return cnt;
  endfunction

  assign sel          = rr_pick(req, ptr_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == CNT_W'(MAX_HOLD));
  assign pend_d       = popcount(req);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_GRANT;
          gnt_d    = N_REQ'(1) << sel;
          gnt_id_d = sel;
          hold_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!req[gnt_id_q] || hold_expired) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          hold_d    = '0;
          ptr_d     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
          // Only a forced exit (holder still requesting) is a timeout.
          timeout_d = req[gnt_id_q];
        end else if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      pend_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = (state_q == ST_GRANT);
  assign pend_cnt  = pend_q;
  assign timeout   = timeout_q;

endmodule
